// File: rtl/tdc_therm_if.sv
// ---------------------------------------------------------------------------
// tdc_therm_if
// Bundles the thermometer-code inputs from the TDC phase detector and the
// decoded phase-error outputs that go to the digital loop filter.
//
// Signals:
//   up_error   [THERM_W] thermometer code of the UP pulse length (LSB-first fill)
//   dwn_error  [THERM_W] thermometer code of the DWN pulse length
//   phase_err  [ERR_W]   signed up_count - dwn_count, held between strobes
//   err_valid            one-cycle strobe qualifying phase_err
//   overflow             timeout or saturated code, presented with err_valid
//   bubble_err           non-thermometric code seen, presented with err_valid
//   busy                 decoder is in any state other than IDLE
//
// Modports:
//   master : detector/loop side, drives the codes and reads the result
//   slave  : the decoder
// ---------------------------------------------------------------------------
interface tdc_therm_if #(
  parameter int THERM_W = 32,
  parameter int ERR_W   = 7
);
  logic        [THERM_W-1:0] up_error;
  logic        [THERM_W-1:0] dwn_error;
  logic signed [ERR_W-1:0]   phase_err;
  logic                      err_valid;
  logic                      overflow;
  logic                      bubble_err;
  logic                      busy;

  modport master (
    output up_error, dwn_error,
    input  phase_err, err_valid, overflow, bubble_err, busy
  );

  modport slave (
    input  up_error, dwn_error,
    output phase_err, err_valid, overflow, bubble_err, busy
  );
endinterface

// File: rtl/tdc_therm_decoder.sv
// ---------------------------------------------------------------------------
// tdc_therm_decoder
// Converts the TDC's thermometer-coded UP/DWN pulse-length words into one
// signed phase error per measurement window. Each window starts when either
// code goes non-zero and ends when both are zero again; the peak length of
// each code over the window is kept, because the detector clears its shift
// registers asynchronously and the final sampled word is not the peak.
//
// Ports:
//   clk    system clock (same clock as the TDC shift registers)
//   reset  synchronous, active-high
//   tdc    tdc_therm_if.slave: up_error/dwn_error in,
//          phase_err/err_valid/overflow/bubble_err/busy out
//
// Build option:
//   TDC_POPCOUNT_EN  when defined, a word's count is its popcount, which
//                    tolerates bubbles; otherwise the count is the position
//                    of the highest set bit. Both agree on clean codes.
//                    bubble_err is reported the same way in both builds.
// ---------------------------------------------------------------------------
module tdc_therm_decoder #(
  parameter int THERM_W     = 32,
  parameter int CNT_W       = 6,
  parameter int ERR_W       = 7,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic      clk,
  input  logic      reset,
  tdc_therm_if.slave tdc
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(THERM_W);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, EMIT, WAIT_CLR} state_t;

  function automatic logic [CNT_W-1:0] therm_count(input logic [THERM_W-1:0] w);
    logic [CNT_W-1:0] c;
    c = '0;
`ifdef TDC_POPCOUNT_EN
    for (int i = 0; i < THERM_W; i++) c = c + CNT_W'(w[i]);
`else
    for (int i = 0; i < THERM_W; i++) if (w[i]) c = CNT_W'(i + 1);
`endif
    return c;
  endfunction

  // A clean code is 2^n-1; adding one then clears every set bit.
  function automatic logic is_bubble(input logic [THERM_W-1:0] w);
    return (w & (w + THERM_W'(1))) != '0;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Counts are at most THERM_W, so the difference always fits in ERR_W.
  function automatic logic signed [ERR_W-1:0] phase_diff(input logic [CNT_W-1:0] up,
                                                         input logic [CNT_W-1:0] dwn);
    logic signed [ERR_W-1:0] su;
    logic signed [ERR_W-1:0] sd;
    su = signed'(ERR_W'(up));
    sd = signed'(ERR_W'(dwn));
    return su - sd;
  endfunction

  logic        [THERM_W-1:0] up_p0, dwn_p0;
  logic signed [ERR_W-1:0]   phase_err_p1;
  logic                      vld_p1, ovf_p1, bub_p1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] peak_up, peak_dwn, peak_up_nxt, peak_dwn_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             bub_flag, bub_nxt, ovf_flag, ovf_nxt, to_flag, to_nxt;
  logic             emit_load, emit_ovf;

  logic [CNT_W-1:0] cnt_up, cnt_dwn;
  logic             bub_now, full_now, any_nz;

  // ---- stage p0: input capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      up_p0  <= '0;
      dwn_p0 <= '0;
    end else begin
      up_p0  <= tdc.up_error;
      dwn_p0 <= tdc.dwn_error;
    end
  end

  assign cnt_up   = therm_count(up_p0);
  assign cnt_dwn  = therm_count(dwn_p0);
  assign bub_now  = is_bubble(up_p0) | is_bubble(dwn_p0);
  assign full_now = (cnt_up == FULL_CNT) | (cnt_dwn == FULL_CNT);
  assign any_nz   = (up_p0 != '0) | (dwn_p0 != '0);

  always_comb begin
    state_nxt    = state;
    peak_up_nxt  = peak_up;
    peak_dwn_nxt = peak_dwn;
    timer_nxt    = timer;
    bub_nxt      = bub_flag;
    ovf_nxt      = ovf_flag;
    to_nxt       = to_flag;
    emit_load    = 1'b0;
    emit_ovf     = 1'b0;
    case (state)
      IDLE: begin
        peak_up_nxt  = '0;
        peak_dwn_nxt = '0;
        timer_nxt    = '0;
        bub_nxt      = 1'b0;
        ovf_nxt      = 1'b0;
        to_nxt       = 1'b0;
        if (any_nz) begin
          state_nxt    = MEASURE;
          peak_up_nxt  = cnt_up;
          peak_dwn_nxt = cnt_dwn;
          bub_nxt      = bub_now;
          ovf_nxt      = full_now;
        end
      end
      MEASURE: begin
        peak_up_nxt  = cnt_max(peak_up, cnt_up);
        peak_dwn_nxt = cnt_max(peak_dwn, cnt_dwn);
        bub_nxt      = bub_flag | bub_now;
        ovf_nxt      = ovf_flag | full_now;
        timer_nxt    = timer + TMR_W'(1);
        // The zero exit is checked first so it wins over a coincident timeout.
        if (!any_nz) begin
          state_nxt = EMIT;
          emit_load = 1'b1;
          emit_ovf  = ovf_nxt;
        end else if (timer == TMR_LAST) begin
          state_nxt = EMIT;
          to_nxt    = 1'b1;
          emit_load = 1'b1;
          emit_ovf  = 1'b1;
        end
      end
      EMIT: begin
        state_nxt = to_flag ? WAIT_CLR : IDLE;
      end
      WAIT_CLR: begin
        if (!any_nz) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      peak_up  <= '0;
      peak_dwn <= '0;
      timer    <= '0;
      bub_flag <= 1'b0;
      ovf_flag <= 1'b0;
      to_flag  <= 1'b0;
    end else begin
      state    <= state_nxt;
      peak_up  <= peak_up_nxt;
      peak_dwn <= peak_dwn_nxt;
      timer    <= timer_nxt;
      bub_flag <= bub_nxt;
      ovf_flag <= ovf_nxt;
      to_flag  <= to_nxt;
    end
  end

  // ---- stage p1: result registers, held between strobes ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      phase_err_p1 <= '0;
      ovf_p1       <= 1'b0;
      bub_p1       <= 1'b0;
    end else begin
      vld_p1 <= emit_load;
      if (emit_load) begin
        phase_err_p1 <= phase_diff(peak_up_nxt, peak_dwn_nxt);
        ovf_p1       <= emit_ovf;
        bub_p1       <= bub_nxt;
      end
    end
  end

  assign tdc.phase_err  = phase_err_p1;
  assign tdc.err_valid  = vld_p1;
  assign tdc.overflow   = ovf_p1;
  assign tdc.bubble_err = bub_p1;
  assign tdc.busy       = (state != IDLE);

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// ---------------------------------------------------------------------------
// tb_tdc_therm_decoder
// Directed bench for tdc_therm_decoder: windows with hand-computed phase
// errors, timeout/overflow, bubble code, mid-window reset and back-to-back
// windows. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tdc_therm_decoder;

  logic clk;
  logic reset;

  tdc_therm_if #(.THERM_W(32), .ERR_W(7)) tdc ();

  tdc_therm_decoder #(
    .THERM_W(32), .CNT_W(6), .ERR_W(7), .TIMEOUT_CYC(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tdc   (tdc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int          nstrobe;
  int          mon_cyc;
  int          strobe_at;
  logic [31:0] st_pe  [0:3];
  logic        st_ovf [0:3];
  logic        st_bub [0:3];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] u, input logic [31:0] d);
    tdc.up_error  = u;
    tdc.dwn_error = d;
    @(negedge clk);
  endtask

  // Drive one cycle and record any strobe seen after the edge.
  task automatic drive_mon(input logic [31:0] u, input logic [31:0] d);
    drive(u, d);
    mon_cyc++;
    if (tdc.err_valid === 1'b1) begin
      if (nstrobe < 4) begin
        st_pe[nstrobe]  = 32'(tdc.phase_err);
        st_ovf[nstrobe] = tdc.overflow;
        st_bub[nstrobe] = tdc.bubble_err;
      end
      strobe_at = mon_cyc;
      nstrobe++;
    end
  endtask

  task automatic mon_clear();
    nstrobe   = 0;
    mon_cyc   = 0;
    strobe_at = -1;
  endtask

  logic [31:0] up_seq [0:7];
  logic [31:0] dn_seq [0:7];

  initial begin
    reset         = 1'b1;
    tdc.up_error  = '0;
    tdc.dwn_error = '0;
    repeat (2) @(negedge clk);
    chk("rst_phase_err", tdc.phase_err, 0);
    chk("rst_err_valid", tdc.err_valid, 0);
    chk("rst_overflow", tdc.overflow, 0);
    chk("rst_bubble", tdc.bubble_err, 0);
    chk("rst_busy", tdc.busy, 0);
    reset = 1'b0;
    drive(0, 0);

    // Window: up peaks at 5, dwn at 3, exact strobe latency.
    drive(32'h1, 32'h1);
    drive(32'h3, 32'h3);
    drive(32'h7, 32'h7);
    drive(32'hF, 32'h7);
    drive(32'h1F, 32'h7);
    drive(0, 0);
    chk("t1_no_early_strobe", tdc.err_valid, 0);
    chk("t1_busy", tdc.busy, 1);
    drive(0, 0);
    chk("t1_err_valid", tdc.err_valid, 1);
    chk("t1_phase_err", tdc.phase_err, 2);
    chk("t1_overflow", tdc.overflow, 0);
    chk("t1_bubble", tdc.bubble_err, 0);
    drive(0, 0);
    chk("t1_single_cycle", tdc.err_valid, 0);
    chk("t1_hold_phase", tdc.phase_err, 2);
    chk("t1_idle_busy", tdc.busy, 0);

    // Window: dwn peaks at 8, up at 3.
    up_seq = '{32'h1, 32'h3, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7};
    dn_seq = '{32'h1, 32'h3, 32'h7, 32'hF, 32'h1F, 32'h3F, 32'h7F, 32'hFF};
    mon_clear();
    for (int i = 0; i < 8; i++) drive_mon(up_seq[i], dn_seq[i]);
    repeat (3) drive_mon(0, 0);
    chk("t2_strobes", nstrobe, 1);
    chk("t2_phase_err", st_pe[0], -5);
    chk("t2_overflow", st_ovf[0], 0);

    // Saturated up code held past the timeout.
    mon_clear();
    repeat (80) drive_mon(32'hFFFF_FFFF, 0);
    chk("t3_strobes", nstrobe, 1);
    chk("t3_strobe_cycle", strobe_at, 66);
    chk("t3_phase_err", st_pe[0], 32);
    chk("t3_overflow", st_ovf[0], 1);
    chk("t3_bubble", st_bub[0], 0);
    chk("t3_busy_wait_clr", tdc.busy, 1);
    repeat (3) drive_mon(0, 0);
    chk("t3_no_second_strobe", nstrobe, 1);
    chk("t3_back_to_idle", tdc.busy, 0);

    // Bubble code 0xB inside the window.
    mon_clear();
    drive_mon(32'h3, 0);
    drive_mon(32'hB, 0);
    drive_mon(32'hF, 0);
    repeat (3) drive_mon(0, 0);
    chk("t4_strobes", nstrobe, 1);
    chk("t4_phase_err", st_pe[0], 4);
    chk("t4_bubble", st_bub[0], 1);
    chk("t4_overflow", st_ovf[0], 0);

    // Reset in the middle of a window.
    mon_clear();
    drive_mon(32'h3, 32'h1);
    drive_mon(32'h7, 32'h1);
    drive_mon(32'hF, 32'h3);
    chk("t5_busy_before", tdc.busy, 1);
    reset = 1'b1;
    drive_mon(32'hF, 32'h3);
    reset = 1'b0;
    repeat (4) drive_mon(0, 0);
    chk("t5_no_strobe", nstrobe, 0);
    chk("t5_phase_err", tdc.phase_err, 0);
    chk("t5_overflow", tdc.overflow, 0);
    chk("t5_bubble", tdc.bubble_err, 0);
    chk("t5_busy", tdc.busy, 0);

    // Two windows separated by one zero cycle.
    mon_clear();
    drive_mon(32'h1, 32'h1);
    drive_mon(32'h3, 32'h1);
    drive_mon(32'h7, 32'h1);
    drive_mon(0, 0);
    drive_mon(32'h1, 32'h1);
    drive_mon(32'h1, 32'h3);
    drive_mon(32'h1, 32'h7);
    drive_mon(32'h1, 32'hF);
    repeat (4) drive_mon(0, 0);
    chk("t6_strobes", nstrobe, 2);
    chk("t6_first_phase", st_pe[0], 2);
    chk("t6_second_phase", st_pe[1], -3);
    chk("t6_second_ovf", st_ovf[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
